instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction-fetch stage of the MIPS datapath: owns the PC, issues word reads to instruction memory over a req/ack handshake, and loads the IF/ID register whose opcode field drives the control unit. It is the producer side of the decode interface, presenting the opcode in `id_opcode` and `id_valid`. It supports decode-stage stall, taken-branch redirect with flush, and memories with arbitrary ack latency.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  read request; held until `imem_ack`
- `imem_addr`  out  32  word address of request; stable while `imem_req` high
- `imem_ack`  in  1  read data valid this cycle; may be high in the first `imem_req` cycle
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack`
- `stall`  in  1  decode cannot accept; IF/ID must hold
- `branch_taken`  in  1  single-cycle redirect pulse
- `branch_target`  in  32  redirect address; bits [1:0] forced to 0
- `id_valid`  out  1  IF/ID holds a live instruction
- `id_instr`  out  32  IF/ID instruction
- `id_pc_plus4`  out  32  address of `id_instr` + 4
- `id_opcode`  out  6  `id_instr[31:26]`, combinational, feeds control unit `instruction`

## Operation
- Registers: `pc` (next address to fetch), `req_addr` (address in flight), 32-bit `buf` plus `buf_pc4`, IF/ID (`id_valid`, `id_instr`, `id_pc_plus4`).
- FSM states:
  - IDLE: entered on reset; `imem_req`=0; unconditional move to REQ.
  - REQ: `imem_req`=1, `imem_addr`=`req_addr`.
  - HOLD: response buffered while decode is stalled; `imem_req`=0.
  - DISCARD: in-flight request made stale by a branch; `imem_req`=1 on the old address.
- REQ, `imem_ack` and no branch:
  - If `!id_valid || !stall`: IF/ID loads `imem_rdata`, `req_addr`+4.
  - Otherwise: `buf` loads the data and the state moves to HOLD.
  - In both cases `pc` and `req_addr` advance by 4, mod 2^32.
- REQ, `branch_taken`:
  - `pc` and `req_addr` take the target.
  - `id_valid` is cleared.
  - With `imem_ack` in the same cycle: data is dropped and the state stays REQ.
  - Without `imem_ack`: the state moves to DISCARD, and `imem_addr` keeps the old address until ack.
- DISCARD:
  - On `imem_ack`: data is dropped; the next request uses `pc` and the state moves to REQ.
  - A further `branch_taken` overwrites `pc` (newest target wins).
- HOLD:
  - `!stall`: IF/ID loads from `buf`; the state moves to REQ.
  - `branch_taken`: the buffer is dropped, `id_valid` cleared, `pc` takes the target, and the state moves to REQ.
- IF/ID with no load this cycle:
  - `stall` high: hold.
  - `stall` low: `id_valid` goes to 0 (consumed).
- Priority: `branch_taken` > `stall`. Flush occurs even when stalled.
- `id_instr`/`id_pc_plus4` are not cleared on flush; only `id_valid` drops.

## Timing
- Reset (async assert) values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, state IDLE, `pc`=`req_addr`=`RESET_PC`.
  - `id_valid`=0, `id_instr`=0, `id_pc_plus4`=0, `id_opcode`=0.
- First edge after reset release: IDLE to REQ. `imem_req` is high in the second cycle.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, and `id_valid` rises 1 edge after ack.
- Branch-to-valid-target latency with zero-wait memory: `id_valid` for the target instruction is 2 edges after the `branch_taken` edge.
- Reset asserted mid-request: the handshake is abandoned. Any later `imem_ack` is ignored until the state reaches REQ.
- `imem_ack` while `imem_req`=0 is ignored.

## Structure
- Shared package `cpu_pkg`: `fetch_state_t` enum (IDLE, REQ, HOLD, DISCARD), `NOP_INSTR` = 32'h0, `OPCODE_MSB`/`OPCODE_LSB` = 31/26, `INSTR_BYTES` = 4.
- No sub-module. The FSM, PC, buffer, and IF/ID register live in one module of roughly 150–250 lines.

## Test plan
- Reset release, zero-wait memory returning 32'h8C01_0004 at address 0 → `imem_req` rises in cycle 2. One edge after ack: `id_valid`=1, `id_opcode`=6'h23, `id_pc_plus4`=4.
- Ack delayed 3 cycles → `imem_addr` stays stable for all 4 request cycles, and exactly one IF/ID load occurs.
- `stall` high for 4 cycles with `id_valid`=1 while the next ack arrives → state HOLD and `imem_req`=0. `id_instr` is unchanged. Once `stall` drops, the buffered word appears next cycle with no loss and no duplication.
- `branch_taken`, target 32'h0000_0040, raised with a 2-cycle-latency request outstanding → the stale data is dropped and `id_valid`=0. The next request address is 0x40, and `id_pc_plus4`=0x44.
- `branch_taken` during HOLD with `stall`=1 → the buffer is discarded, `id_valid`=0, and fetch resumes at the target.
- Branch target 32'h0000_0043 → `imem_addr`=0x40. Then PC 32'hFFFF_FFFC with a sequential fetch → next `imem_addr`=0 (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the instruction fetch unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          OPCODE_MSB  = 31;
  localparam int          OPCODE_LSB  = 26;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, imem req/ack handshake,
// one-word skid buffer and the IF/ID register.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc4_q, id_pc4_d;

  logic [31:0]  tgt;
  logic [31:0]  seq;

  assign tgt = word_align(branch_target);
  assign seq = req_addr_q + INSTR_BYTES;

  // Next-state, datapath updates and request output.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    buf_pc4_d  = buf_pc4_q;
    id_valid_d = stall ? id_valid_q : 1'b0;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    imem_req   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_taken) begin
          pc_d       = tgt;
          req_addr_d = tgt;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d = tgt;
          // With an ack the stale word is
          // dropped here; otherwise the old
          // request must still complete.
          if (imem_ack) begin
            req_addr_d = tgt;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          pc_d       = seq;
          req_addr_d = seq;
          if (!id_valid_q || !stall) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc4_d   = seq;
          end else begin
            buf_d     = imem_rdata;
            buf_pc4_d = seq;
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = REQ;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = buf_q;
          id_pc4_d   = buf_pc4_q;
          state_d    = REQ;
        end
      end

      DISCARD: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d = tgt;
        end
        // Newest target (possibly this
        // cycle's) becomes the next fetch.
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (branch_taken) begin
      id_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= NOP_INSTR;
      buf_pc4_q  <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      buf_pc4_q  <= buf_pc4_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  assign imem_addr   = req_addr_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc4_q;
  assign id_opcode   =
    id_instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule
